// File: rtl/qcs_fir_pkg.sv
// Shared types and default widths for the FIR I/Q sample driver slice.
package qcs_fir_pkg;

    localparam int unsigned QCS_DW_DEF    = 16;
    localparam int unsigned QCS_NCH_DEF   = 2;
    localparam int unsigned QCS_DEPTH_DEF = 8;
    localparam int unsigned QCS_GAPW_DEF  = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_SEND = S_SEND,
        ST_GAP  = S_GAP
    } smp_drv_state_e;

    // Default-width buffer entry; the driver declares its own copy sized by its parameters.
    typedef struct packed {
        logic [QCS_NCH_DEF*QCS_DW_DEF-1:0] i;
        logic [QCS_NCH_DEF*QCS_DW_DEF-1:0] q;
        logic                              last;
    } smp_entry_t;

endpackage

// File: rtl/qcs_fir_smp_drv_if.sv
// Upstream ready/valid sample stream into the FIR sample driver.
interface qcs_fir_smp_drv_if
    import qcs_fir_pkg::*;
#(
    parameter int unsigned DW  = QCS_DW_DEF,
    parameter int unsigned NCH = QCS_NCH_DEF
);
    logic              s_vld;
    logic              s_rdy;
    logic              s_last;
    logic [NCH*DW-1:0] s_data_i;
    logic [NCH*DW-1:0] s_data_q;

    modport master (output s_vld, s_last, s_data_i, s_data_q, input s_rdy);
    modport slave  (input s_vld, s_last, s_data_i, s_data_q, output s_rdy);
endinterface

// File: rtl/qcs_fir_smp_fifo.sv
// Synchronous FIFO with registered occupancy; no write-through and no bypass.
module qcs_fir_smp_fifo
    import qcs_fir_pkg::*;
#(
    parameter int unsigned WIDTH = 2*QCS_NCH_DEF*QCS_DW_DEF+1,
    parameter int unsigned DEPTH = QCS_DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == FULL_LVL);
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/qcs_fir_smp_drv.sv
// Multi-channel I/Q sample driver: buffers upstream samples and replays them paced by cfg_gap.
// Build option QCS_FIR_DRV_X_FILL_EN: drive data outputs to X while data_vld is low.
module qcs_fir_smp_drv
    import qcs_fir_pkg::*;
#(
    parameter int unsigned DW    = QCS_DW_DEF,
    parameter int unsigned NCH   = QCS_NCH_DEF,
    parameter int unsigned DEPTH = QCS_DEPTH_DEF,
    parameter int unsigned GAPW  = QCS_GAPW_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cfg_en,
    input  logic [GAPW-1:0]        cfg_gap,
    qcs_fir_smp_drv_if.slave       smp,
    output logic                   data_vld,
    output logic [NCH*DW-1:0]      data_i,
    output logic [NCH*DW-1:0]      data_q,
    output logic                   underrun,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] level
);
    localparam int unsigned BW = NCH*DW;

    typedef struct packed {
        logic [BW-1:0] i;
        logic [BW-1:0] q;
        logic          last;
    } entry_t;

    entry_t          wr_entry;
    entry_t          rd_entry;
    logic            full;
    logic            empty;
    logic            rdy;
    logic            push;
    logic            pop;
    logic            due;
    logic [1:0]      state_q, state_d;
    logic [GAPW-1:0] cnt_q, cnt_d;
    logic            started_q, started_d;
    logic            last_q;
    logic            underrun_d;

    assign rdy       = !full && !reset;
    assign smp.s_rdy = rdy;
    assign push      = smp.s_vld && rdy;
    assign wr_entry  = '{i: smp.s_data_i, q: smp.s_data_q, last: smp.s_last};
    assign busy      = started_q;

    qcs_fir_smp_fifo #(
        .WIDTH (2*BW+1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (wr_entry),
        .rdata (rd_entry),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    // A zero gap makes the next sample due in the SEND cycle itself, giving back-to-back output.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        started_d  = started_q;
        pop        = 1'b0;
        due        = 1'b0;
        underrun_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cfg_en && !empty) begin
                    pop       = 1'b1;
                    state_d   = S_SEND;
                    started_d = 1'b1;
                end
            end
            S_SEND: begin
                cnt_d = cfg_gap;
                if (last_q) begin
                    started_d = 1'b0;
                    state_d   = (cfg_gap != '0) ? S_GAP : S_IDLE;
                end else if (cfg_gap != '0) begin
                    state_d = S_GAP;
                end else begin
                    due = 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q == GAPW'(1)) due = 1'b1;
                else                   cnt_d = cnt_q - 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (due) begin
            if (!cfg_en) begin
                state_d = S_IDLE;
            end else if (!empty) begin
                pop       = 1'b1;
                state_d   = S_SEND;
                started_d = 1'b1;
            end else begin
                underrun_d = started_q;
                started_d  = 1'b0;
                state_d    = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            started_q <= 1'b0;
            last_q    <= 1'b0;
            underrun  <= 1'b0;
            data_vld  <= 1'b0;
            data_i    <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            started_q <= started_d;
            underrun  <= underrun_d;
            data_vld  <= pop;
            if (pop) begin
                data_i <= rd_entry.i;
                data_q <= rd_entry.q;
                last_q <= rd_entry.last;
            end else begin
`ifdef QCS_FIR_DRV_X_FILL_EN
                data_i <= 'x;
                data_q <= 'x;
`else
                data_i <= '0;
                data_q <= '0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_qcs_fir_smp_drv.sv
// Directed self-checking bench for qcs_fir_smp_drv.
`timescale 1ns/1ps
module tb_qcs_fir_smp_drv;
    localparam int unsigned DW    = 16;
    localparam int unsigned NCH   = 2;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned GAPW  = 4;
    localparam int unsigned BW    = NCH*DW;
    localparam int unsigned LW    = $clog2(DEPTH)+1;

    logic            clk = 1'b0;
    logic            reset;
    logic            cfg_en;
    logic [GAPW-1:0] cfg_gap;
    logic            data_vld;
    logic [BW-1:0]   data_i;
    logic [BW-1:0]   data_q;
    logic            underrun;
    logic            busy;
    logic [LW-1:0]   level;

    int checks = 0;
    int errors = 0;

    qcs_fir_smp_drv_if #(.DW(DW), .NCH(NCH)) smp ();

    qcs_fir_smp_drv #(
        .DW    (DW),
        .NCH   (NCH),
        .DEPTH (DEPTH),
        .GAPW  (GAPW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cfg_en   (cfg_en),
        .cfg_gap  (cfg_gap),
        .smp      (smp),
        .data_vld (data_vld),
        .data_i   (data_i),
        .data_q   (data_q),
        .underrun (underrun),
        .busy     (busy),
        .level    (level)
    );

    always #5 clk = ~clk;

    function automatic logic [BW-1:0] mk_i(input int k);
        logic [DW-1:0] lo, hi;
        lo = DW'(k);
        hi = DW'(k + 256);
        return {hi, lo};
    endfunction

    function automatic logic [BW-1:0] mk_q(input int k);
        logic [DW-1:0] lo, hi;
        lo = DW'(k + 512);
        hi = DW'(k + 768);
        return {hi, lo};
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int k, input logic last);
        smp.s_vld    = v;
        smp.s_data_i = mk_i(k);
        smp.s_data_q = mk_q(k);
        smp.s_last   = last;
    endtask

    task automatic test_reset;
        reset = 1'b1; cfg_en = 1'b0; cfg_gap = '0;
        drive(1'b0, 0, 1'b0);
        repeat (3) step;
        checks++; if (smp.s_rdy !== 1'b0) begin errors++; $display("FAIL rst_s_rdy_held got %b exp 0", smp.s_rdy); end
        reset = 1'b0;
        #1;
        checks++; if (smp.s_rdy !== 1'b1) begin errors++; $display("FAIL rst_s_rdy_release got %b exp 1", smp.s_rdy); end
        checks++; if (data_vld !== 1'b0) begin errors++; $display("FAIL rst_data_vld got %b exp 0", data_vld); end
        checks++; if (data_i !== '0) begin errors++; $display("FAIL rst_data_i got %h exp 0", data_i); end
        checks++; if (data_q !== '0) begin errors++; $display("FAIL rst_data_q got %h exp 0", data_q); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL rst_underrun got %b exp 0", underrun); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
        checks++; if (level !== '0) begin errors++; $display("FAIL rst_level got %0d exp 0", level); end
    endtask

    task automatic test_latency_b2b;
        int cyc;
        logic ev, eb;
        cfg_gap = '0; cfg_en = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (c < 4) drive(1'b1, c + 1, c == 3);
            else       drive(1'b0, 0, 1'b0);
            step;
            cyc = c + 1;
            ev  = (cyc >= 2 && cyc <= 5);
            eb  = (cyc >= 2 && cyc <= 5);
            checks++; if (data_vld !== ev) begin errors++; $display("FAIL b2b_vld cyc %0d got %b exp %b", cyc, data_vld, ev); end
            if (ev) begin
                checks++; if (data_i !== mk_i(cyc - 1)) begin errors++; $display("FAIL b2b_data_i cyc %0d got %h exp %h", cyc, data_i, mk_i(cyc - 1)); end
                checks++; if (data_q !== mk_q(cyc - 1)) begin errors++; $display("FAIL b2b_data_q cyc %0d got %h exp %h", cyc, data_q, mk_q(cyc - 1)); end
            end
`ifndef QCS_FIR_DRV_X_FILL_EN
            else begin
                checks++; if (data_i !== '0) begin errors++; $display("FAIL b2b_idle_data cyc %0d got %h exp 0", cyc, data_i); end
            end
`endif
            checks++; if (busy !== eb) begin errors++; $display("FAIL b2b_busy cyc %0d got %b exp %b", cyc, busy, eb); end
            checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL b2b_underrun cyc %0d got %b exp 0", cyc, underrun); end
        end
    endtask

    task automatic test_gap_spacing;
        int cyc, el, ek;
        logic ev, eb;
        cfg_en = 1'b0; cfg_gap = 4'd3;
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 11 + c, c == 2);
            step;
        end
        drive(1'b0, 0, 1'b0);
        checks++; if (level !== LW'(3)) begin errors++; $display("FAIL gap_level_pre got %0d exp 3", level); end
        cfg_en = 1'b1;
        for (int c = 3; c < 17; c++) begin
            step;
            cyc = c + 1;
            ev  = (cyc == 4 || cyc == 8 || cyc == 12);
            ek  = 11 + (cyc - 4) / 4;
            el  = (cyc < 8) ? 2 : (cyc < 12) ? 1 : 0;
            eb  = (cyc >= 4 && cyc <= 12);
            checks++; if (data_vld !== ev) begin errors++; $display("FAIL gap_vld cyc %0d got %b exp %b", cyc, data_vld, ev); end
            if (ev) begin
                checks++; if (data_i !== mk_i(ek)) begin errors++; $display("FAIL gap_data_i cyc %0d got %h exp %h", cyc, data_i, mk_i(ek)); end
            end
            checks++; if (level !== LW'(el)) begin errors++; $display("FAIL gap_level cyc %0d got %0d exp %0d", cyc, level, el); end
            checks++; if (busy !== eb) begin errors++; $display("FAIL gap_busy cyc %0d got %b exp %b", cyc, busy, eb); end
            checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL gap_underrun cyc %0d got %b exp 0", cyc, underrun); end
        end
    endtask

    task automatic test_underrun;
        int cyc;
        logic ev, eu, eb;
        cfg_en = 1'b1; cfg_gap = 4'd1;
        for (int c = 0; c < 10; c++) begin
            drive(c < 2, 21 + c, 1'b0);
            step;
            cyc = c + 1;
            ev  = (cyc == 2 || cyc == 4);
            eu  = (cyc == 6);
            eb  = (cyc >= 2 && cyc <= 5);
            checks++; if (data_vld !== ev) begin errors++; $display("FAIL und_vld cyc %0d got %b exp %b", cyc, data_vld, ev); end
            if (ev) begin
                checks++; if (data_i !== mk_i(20 + cyc / 2)) begin errors++; $display("FAIL und_data_i cyc %0d got %h exp %h", cyc, data_i, mk_i(20 + cyc / 2)); end
            end
            checks++; if (underrun !== eu) begin errors++; $display("FAIL und_pulse cyc %0d got %b exp %b", cyc, underrun, eu); end
            checks++; if (busy !== eb) begin errors++; $display("FAIL und_busy cyc %0d got %b exp %b", cyc, busy, eb); end
        end
    endtask

    task automatic test_full_buffer;
        int m, el;
        logic ev, eu;
        cfg_en = 1'b0; cfg_gap = '0;
        for (int c = 0; c < 10; c++) begin
            drive(1'b1, 31 + c, 1'b0);
            #1;
            checks++; if (smp.s_rdy !== (c < 8)) begin errors++; $display("FAIL full_s_rdy cyc %0d got %b exp %b", c, smp.s_rdy, c < 8); end
            step;
        end
        drive(1'b0, 0, 1'b0);
        checks++; if (level !== LW'(8)) begin errors++; $display("FAIL full_level got %0d exp 8", level); end
        cfg_en = 1'b1;
        for (int j = 0; j < 11; j++) begin
            step;
            m  = j + 1;
            ev = (m <= 8);
            eu = (m == 9);
            el = (m <= 8) ? 8 - m : 0;
            checks++; if (data_vld !== ev) begin errors++; $display("FAIL full_vld m %0d got %b exp %b", m, data_vld, ev); end
            if (ev) begin
                checks++; if (data_i !== mk_i(30 + m)) begin errors++; $display("FAIL full_order m %0d got %h exp %h", m, data_i, mk_i(30 + m)); end
            end
            checks++; if (level !== LW'(el)) begin errors++; $display("FAIL full_drain_level m %0d got %0d exp %0d", m, level, el); end
            checks++; if (underrun !== eu) begin errors++; $display("FAIL full_underrun m %0d got %b exp %b", m, underrun, eu); end
        end
    endtask

    task automatic test_reset_mid_burst;
        cfg_en = 1'b0; cfg_gap = 4'd3;
        for (int c = 0; c < 6; c++) begin
            drive(1'b1, 41 + c, 1'b0);
            step;
        end
        drive(1'b0, 0, 1'b0);
        checks++; if (level !== LW'(6)) begin errors++; $display("FAIL mid_level_pre got %0d exp 6", level); end
        cfg_en = 1'b1;
        step;
        checks++; if (data_vld !== 1'b1 || data_i !== mk_i(41)) begin errors++; $display("FAIL mid_first got %b/%h exp 1/%h", data_vld, data_i, mk_i(41)); end
        step;
        checks++; if (level !== LW'(5) || busy !== 1'b1) begin errors++; $display("FAIL mid_gap_state got lvl %0d busy %b exp 5 1", level, busy); end
        reset = 1'b1;
        step;
        checks++; if (level !== '0) begin errors++; $display("FAIL mid_rst_level got %0d exp 0", level); end
        checks++; if (data_vld !== 1'b0) begin errors++; $display("FAIL mid_rst_vld got %b exp 0", data_vld); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got %b exp 0", busy); end
        checks++; if (smp.s_rdy !== 1'b0) begin errors++; $display("FAIL mid_rst_s_rdy got %b exp 0", smp.s_rdy); end
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step;
            checks++; if (data_vld !== 1'b0 || level !== '0) begin errors++; $display("FAIL mid_stale cyc %0d got vld %b lvl %0d exp 0 0", c, data_vld, level); end
        end
        drive(1'b1, 85, 1'b1);
        step;
        drive(1'b0, 0, 1'b0);
        step;
        checks++; if (data_vld !== 1'b1) begin errors++; $display("FAIL mid_fresh_vld got %b exp 1", data_vld); end
        checks++; if (data_i !== mk_i(85)) begin errors++; $display("FAIL mid_fresh_data got %h exp %h", data_i, mk_i(85)); end
    endtask

    initial begin
        test_reset;
        test_latency_b2b;
        repeat (3) step;
        test_gap_spacing;
        repeat (3) step;
        test_underrun;
        repeat (3) step;
        test_full_buffer;
        repeat (3) step;
        test_reset_mid_burst;
        repeat (6) step;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

endmodule

// File: doc/qcs_fir_smp_drv.md
# qcs_fir_smp_drv

Synthesisable multi-channel I/Q sample driver feeding the FIR datapath. Accepts packed I/Q sample vectors from an upstream source through a ready/valid buffer, then replays them on the FIR `data_vld`/`data_i`/`data_q` port with a programmable inter-sample gap and burst framing. It flags underruns and supplies a FIFO level for monitoring. It generalises the single-channel, fixed-rate FIR input drive in channel count, buffering and pacing.

## Interface
- `DW`, 16: sample width per component (I or Q), ≥ 2.
- `NCH`, 2: channel count; all channels share one valid.
- `DEPTH`, 8: buffer entries; power of 2, ≥ 2.
- `GAPW`, 4: width of the gap configuration field.

- `clk`  in  1: clock; all logic on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `cfg_en`  in  1: enables output streaming.
- `cfg_gap`  in  GAPW: idle cycles inserted after each output sample.
- `s_vld`  in  1: upstream sample valid.
- `s_rdy`  out  1: buffer can accept; equals !full.
- `s_last`  in  1: marks the final sample of a burst.
- `s_data_i`  in  NCH*DW: I components; channel c occupies `[c*DW +: DW]`.
- `s_data_q`  in  NCH*DW: Q components, same packing as `s_data_i`.
- `data_vld`  out  1: FIR sample valid.
- `data_i`  out  NCH*DW: FIR I data.
- `data_q`  out  NCH*DW: FIR Q data.
- `underrun`  out  1: one-cycle pulse when a sample is due but the buffer is empty.
- `busy`  out  1: high while a burst is in progress (`started`).
- `level`  out  $clog2(DEPTH)+1: buffer occupancy, 0..DEPTH.

## Operation
- **Buffer write:** an entry is written when `s_vld && s_rdy`. An entry holds {i, q, last}.
- **Buffer full:** `s_rdy` = 0. There is no write-through at full, even if a pop occurs in the same cycle.
- **Buffer empty:** there is no bypass; a push and a pop never target the same entry in one cycle.
- **FSM states:** IDLE, SEND, GAP.
- **IDLE → SEND:** when `cfg_en` and the buffer is not empty. The transition pops the head entry into the output registers. `started` is set to 1.
- **SEND:** lasts exactly one cycle with `data_vld` = 1.
  - If the entry had `last` = 1: clear `started`; go to GAP if `cfg_gap` ≠ 0, else IDLE.
  - Otherwise: go to GAP with counter = `cfg_gap` if `cfg_gap` ≠ 0. If `cfg_gap` = 0, the sample is due immediately and the due-sample rule applies in the same cycle (back-to-back samples).
- **GAP:** `data_vld` = 0 and the counter decrements each cycle. When the counter reaches 1, the next sample is due.
- **Sample due:**
  - If `cfg_en` = 0: go to IDLE and keep `started`.
  - If the buffer is not empty: pop and go to SEND.
  - If the buffer is empty and `started` = 1: pulse `underrun`, clear `started`, go to IDLE.
  - If the buffer is empty and `started` = 0: go to IDLE silently.
- **Configuration sampling:** `cfg_gap` is sampled on the SEND cycle only; changes during GAP take effect on the following sample.
- **Disable:** deasserting `cfg_en` never truncates the current SEND or GAP. Buffer contents are retained.
- **Reset:** `reset` mid-operation flushes the buffer, returns the FSM to IDLE and clears `started`/`underrun` at that edge. Any in-flight output is dropped.
- **`level`:** registered occupancy. A simultaneous push and pop leaves it unchanged.

## Timing
- **Reset values:** `data_vld` 0, `data_i`/`data_q` 0, `s_rdy` 0 during reset then 1, `underrun` 0, `busy` 0, `level` 0.
- **Input-to-output latency:** a sample accepted in cycle n (empty buffer, IDLE, `cfg_en` = 1) appears with `data_vld` = 1 in cycle n+2.
- **Output spacing:** steady-state spacing between `data_vld` pulses is `cfg_gap` + 1 cycles. With `cfg_gap` = 0 and a non-empty buffer, `data_vld` is held high continuously.
- **`underrun` timing:** the pulse is registered and appears in the cycle following the due cycle.
- All outputs are registered; there are no combinational paths from input to output except `s_rdy`, which is derived from registered `level`.

## Configuration
- `QCS_FIR_DRV_X_FILL_EN` defined: `data_i`/`data_q` are driven to all-X in every cycle where `data_vld` = 0 after reset, so downstream capture of invalid data shows in simulation.
- Undefined: the data outputs are driven to 0 whenever `data_vld` = 0. Reset values are identical in both builds.

## Structure
- **`qcs_fir_pkg`:**
  - `smp_drv_state_e` (IDLE/SEND/GAP).
  - `smp_entry_t` struct parametrised by usage, holding i, q and last.
  - Localparam default widths.
- **Sub-module `qcs_fir_smp_fifo`:** synchronous FIFO with parameters `WIDTH` and `DEPTH`, ports push/pop/full/empty/level. The driver instantiates it once with `WIDTH = 2*NCH*DW+1`.

## Test plan
- **Reset values:** hold reset for 3 cycles, release → all outputs at reset values; `s_rdy` = 1 in the first cycle after release.
- **Latency and back-to-back:** `cfg_gap` = 0, push 4 samples (I = 1..4, last on 4) → `data_vld` high cycles 2–5 with I = 1,2,3,4; `busy` falls after 4; no underrun.
- **Gap spacing:** `cfg_gap` = 3, push 3 samples back-to-back → `data_vld` pulses exactly 4 cycles apart; `level` goes 3→0.
- **Underrun:** `cfg_gap` = 1, push 2 samples without last, then stop → one `underrun` pulse 1 cycle after the third due slot; FSM returns to IDLE.
- **Full buffer:** `DEPTH` = 8, `cfg_en` = 0, push 10 → `s_rdy` = 0 after 8 accepts, `level` = 8; enable → 8 samples out in order.
- **Reset mid-burst:** assert reset during GAP with 5 buffered → next cycle `level` = 0, `data_vld` = 0; no stale samples after release.
